// File: rtl/clk_logic_unit.sv
// clk_logic_unit: pipelined bitwise logic unit with sticky AND accumulator and global stall
module clk_logic_unit #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_clr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             y_zero
);
  logic             stall;
  logic             accept;
  logic             z;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] res;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] vc;
  logic [WIDTH-1:0] r  [STAGES];
  logic [WIDTH-1:0] rc [STAGES];

  assign stall    = y_valid && !y_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign acc_base = acc_clr ? '1 : acc;
  assign acc_next = acc_base & a & b;

  // operation select; op 7 returns the freshly accumulated value
  always_comb begin
    res = acc_next;
    case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: res = a ^ b;
      3'd3: res = ~(a & b);
      3'd4: res = ~(a | b);
      3'd5: res = ~(a ^ b);
      3'd6: res = a & ~b;
      default: res = acc_next;
    endcase
  end

  // input of each stage: stage 0 takes the new result, the rest take their predecessor
  always_comb begin
    vc[0] = accept;
    rc[0] = res;
    for (int i = 1; i < STAGES; i++) begin
      vc[i] = v[i-1];
      rc[i] = r[i-1];
    end
  end

  // valid/result shift chain, frozen as a whole while the sink stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
      z <= 1'b0;
      for (int i = 0; i < STAGES; i++) r[i] <= '0;
    end else if (!stall) begin
      v <= vc;
      z <= vc[STAGES-1] && (rc[STAGES-1] == '0);
      for (int i = 0; i < STAGES; i++) r[i] <= rc[i];
    end
  end

  // accumulator moves only on accepted operands; acc_clr on other ops just restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc <= '1;
    else if (accept) acc <= (op == 3'd7) ? acc_next : (acc_clr ? '1 : acc);
  end

  assign Y       = r[STAGES-1];
  assign y_valid = v[STAGES-1];
  assign y_zero  = z;
endmodule

// File: doc/clk_logic_unit.md
# clk_logic_unit

Parametrised, pipelined bitwise logic unit: successor to the single-function clocked 8-bit AND block. Two WIDTH-bit operands are combined under a runtime-selected operation (seven bitwise functions plus a sticky AND-accumulate). Results pass through a STAGES-deep valid/ready pipeline with global stall. It sits between the pin wrapper and the operand sources/result sink, replacing the fixed clocked AND core.

## Interface
- WIDTH, 8: operand/result width, 1..32.
- STAGES, 2: pipeline depth (latency in cycles), 1..4.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation select, sampled with the operands.
- acc_clr  in  1  accumulator restart qualifier, sampled with the operands.
- in_valid  in  1  operands/op present.
- in_ready  out  1  unit accepts this cycle.
- Y  out  WIDTH  result.
- y_valid  out  1  Y holds a result.
- y_ready  in  1  sink accepts Y.
- y_zero  out  1  Y == 0, qualified by y_valid.

## Operation
- Accept = in_valid && in_ready. Only accepted operands enter stage 1; otherwise a bubble (valid=0) enters.
- op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a & ~b), 7 ACC.
- ACC: internal register acc (WIDTH, reset all ones). On an accepted op 7: acc_next = (acc_clr ? all-ones : acc) & a & b; acc <= acc_next; the result is acc_next.
- acc_clr on an accepted op 0..6: acc <= all ones; the result is the normal op. acc_clr without accept: ignored.
- acc changes only on accept; stalls and bubbles leave it unchanged.
- Result is computed combinationally at accept and registered into stage 1; stages 2..STAGES are pure delay registers, each carrying {valid, result}.
- Y, y_valid = last stage. y_zero = y_valid && (Y == 0), registered with the last stage (no combinational path from Y).
- Global stall: stall = y_valid && !y_ready. While stall, every stage (including y_zero) holds and acc holds.
- in_ready = !stall (combinational from y_valid, y_ready). Bubbles are not collapsed.
- No state machine beyond the valid shift chain. Width rule: all ops are bitwise, with no carries or truncation.

## Timing
- Reset (async assert, sync-released use): Y=0, y_valid=0, y_zero=0, all stage valids 0, acc = all ones, in_ready=1.
- Reset mid-operation: in-flight results are discarded, and acc returns to all ones in the same instant.
- Latency: accepted at edge k -> Y/y_valid at edge k+STAGES, absent stalls. Throughput: 1 per cycle.
- Stall of n cycles delays every in-flight result by exactly n cycles; order is preserved and nothing is lost or duplicated.
- Simultaneous y_ready rising and in_valid in the same cycle: accepted, and the pipeline advances in one edge.
- Y is stable while y_valid && !y_ready.
- A pipeline full of valid data under continuous y_ready=1 never deasserts in_ready.

## Test plan
- WIDTH=8, STAGES=2. Stream a=0xF0 and b=0x3C with op 0..6 on consecutive cycles, y_ready=1 -> Y = 0x30, 0xFC, 0xCC, 0xCF, 0x03, 0x33, 0xC0 appear 2 cycles after each accept, back-to-back; y_zero=0 throughout.
- ACC: after reset, apply op=7 with (a,b) = (0xFE,0xFF), then (0xFF,0x7F), then (0x0F,0xFF) -> Y = 0xFE, 0x7E, 0x0E. Next, op=7 with acc_clr=1 and a=b=0xAA -> Y = 0xAA. Then op=7 with a=0x55, b=0xFF -> Y = 0x00 and y_zero=1.
- Backpressure: issue 4 accepted ops, hold y_ready=0 for 5 cycles after the first result -> in_ready=0 and Y held for exactly those cycles; acc is unchanged by an op 7 presented during the stall. Releasing y_ready yields all 4 results in order with no gaps.
- Bubbles: in_valid toggles 1,0,1 -> y_valid toggles 1,0,1 two cycles later; acc is untouched on the bubble cycle even with op=7 and acc_clr=1.
- Async reset mid-stream: assert reset between edges with 2 results in flight and acc=0x0E -> Y=0, y_valid=0, and y_zero=0 immediately. The next op=7 with a=b=0xFF yields 0xFF.
- Sweep STAGES=1 and 4, WIDTH=1 and 32. Random op/operand/valid/ready traffic checked against a reference queue model -> zero mismatches over 10k cycles.
